m_cache_controller: RTL and testbench

- Read-side controller sequencing the 32-entry direct-mapped cache (58-bit lines: valid, 25-bit tag, 32-bit data; index = address[6:2], tag = address[31:7]).
- Accepts one CPU read at a time and looks it up in the cache.
- On a miss, fetches the word from backing memory over a req/ack handshake, fills the line, then returns the data.
- Also keeps saturating hit and miss statistics counters.

---
 rtl/m_cache_controller.sv | 157 +++++++++++++++
 tb/tb_m_cache_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cache_controller.sv
// Read-side controller for a 32-entry direct-mapped cache: lookup, memory fetch
// on a miss over a req/ack handshake, line fill, and saturating hit/miss counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a CPU read; latches the request address
// S_LOOKUP | cache output valid for the latched address; a hit responds
// S_MFETCH | memory request outstanding; timer counts down to a timeout
// S_FILL   | line write pulse on the cache port; response raised
// S_RESP   | response (normal or timeout) pulse ends; back to idle
module m_cache_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             w_clock,
  input  logic             w_reset_n,
  input  logic             w_req,
  input  logic [31:0]      w_addr,
  output logic             w_busy,
  output logic             w_ready,
  output logic [31:0]      w_rdata,
  output logic             w_err,
  output logic [31:0]      w_c_addr,
  input  logic             w_c_hit,
  input  logic [31:0]      w_c_dout,
  output logic             w_c_we,
  output logic [4:0]       w_c_wa,
  output logic [57:0]      w_c_wd,
  output logic             w_m_req,
  output logic [31:0]      w_m_addr,
  input  logic             w_m_ack,
  input  logic [31:0]      w_m_rdata,
  output logic [CNT_W-1:0] w_hit_cnt,
  output logic [CNT_W-1:0] w_miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MFETCH,
    S_FILL,
    S_RESP
  } state_t;

  // Down-counter loaded on a miss; reaching zero without an ack is the timeout.
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       timer_q, timer_d;
  logic              ready_d, err_d, c_we_d, m_req_d;
  logic [31:0]       rdata_d, m_addr_d;
  logic [4:0]        c_wa_d;
  logic [57:0]       c_wd_d;
  logic [CNT_W-1:0]  hit_d, miss_d;

  assign w_c_addr = addr_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    timer_d  = timer_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    c_we_d   = 1'b0;
    rdata_d  = w_rdata;
    c_wa_d   = w_c_wa;
    c_wd_d   = w_c_wd;
    m_req_d  = w_m_req;
    m_addr_d = w_m_addr;
    hit_d    = w_hit_cnt;
    miss_d   = w_miss_cnt;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          addr_d  = w_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_c_hit) begin
          rdata_d = w_c_dout;
          ready_d = 1'b1;
          if (w_hit_cnt != {CNT_W{1'b1}}) hit_d = w_hit_cnt + CNT_W'(1);
          state_d = S_IDLE;
        end else begin
          if (w_miss_cnt != {CNT_W{1'b1}}) miss_d = w_miss_cnt + CNT_W'(1);
          m_req_d  = 1'b1;
          m_addr_d = {addr_q[31:2], 2'b00};
          timer_d  = TIMER_LOAD;
          state_d  = S_MFETCH;
        end
      end
      S_MFETCH: begin
        if (w_m_ack) begin
          m_req_d = 1'b0;
          c_we_d  = 1'b1;
          c_wa_d  = addr_q[6:2];
          c_wd_d  = {1'b1, addr_q[31:7], w_m_rdata};
          rdata_d = w_m_rdata;
          state_d = S_FILL;
        end else if (timer_q == 16'd0) begin
          m_req_d = 1'b0;
          err_d   = 1'b1;
          ready_d = 1'b1;
          rdata_d = 32'd0;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_FILL: begin
        ready_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      timer_q    <= 16'd0;
      w_busy     <= 1'b0;
      w_ready    <= 1'b0;
      w_err      <= 1'b0;
      w_rdata    <= 32'd0;
      w_c_we     <= 1'b0;
      w_c_wa     <= 5'd0;
      w_c_wd     <= 58'd0;
      w_m_req    <= 1'b0;
      w_m_addr   <= 32'd0;
      w_hit_cnt  <= '0;
      w_miss_cnt <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      w_busy     <= (state_d != S_IDLE);
      w_ready    <= ready_d;
      w_err      <= err_d;
      w_rdata    <= rdata_d;
      w_c_we     <= c_we_d;
      w_c_wa     <= c_wa_d;
      w_c_wd     <= c_wd_d;
      w_m_req    <= m_req_d;
      w_m_addr   <= m_addr_d;
      w_hit_cnt  <= hit_d;
      w_miss_cnt <= miss_d;
    end
  end

endmodule

// File: tb/tb_m_cache_controller.sv
// Bench for m_cache_controller: cache array and memory responder around the DUT,
// a transaction-level timing model checked every cycle, plus literal spot checks.
module tb_m_cache_controller;

  localparam int TO = 8;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          w_clock = 1'b0;
  logic          w_reset_n = 1'b0;
  logic          w_req = 1'b0;
  logic [31:0]   w_addr = 32'd0;
  logic          w_busy, w_ready, w_err, w_c_we, w_m_req;
  logic [31:0]   w_rdata, w_c_addr, w_m_addr;
  logic          w_c_hit;
  logic [31:0]   w_c_dout;
  logic [4:0]    w_c_wa;
  logic [57:0]   w_c_wd;
  logic          w_m_ack = 1'b0;
  logic [31:0]   w_m_rdata = 32'd0;
  logic [CW-1:0] w_hit_cnt, w_miss_cnt;

  m_cache_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .w_clock(w_clock), .w_reset_n(w_reset_n), .w_req(w_req), .w_addr(w_addr),
    .w_busy(w_busy), .w_ready(w_ready), .w_rdata(w_rdata), .w_err(w_err),
    .w_c_addr(w_c_addr), .w_c_hit(w_c_hit), .w_c_dout(w_c_dout),
    .w_c_we(w_c_we), .w_c_wa(w_c_wa), .w_c_wd(w_c_wd),
    .w_m_req(w_m_req), .w_m_addr(w_m_addr), .w_m_ack(w_m_ack), .w_m_rdata(w_m_rdata),
    .w_hit_cnt(w_hit_cnt), .w_miss_cnt(w_miss_cnt)
  );

  always #5 w_clock = ~w_clock;

  int cyc = 0;
  always @(posedge w_clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge w_clock);
    #1;
  endtask

  // ---- environment: cache array and memory responder ----
  logic [57:0] cache_mem [32] = '{default: 58'd0};
  logic [57:0] line;
  assign line     = cache_mem[w_c_addr[6:2]];
  assign w_c_hit  = line[57] && (line[56:32] == w_c_addr[31:7]);
  assign w_c_dout = line[31:0];
  always @(posedge w_clock) if (w_c_we) cache_mem[w_c_wa] <= w_c_wd;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
    if (a == 32'h0000_0084) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  int mem_delay = 1;
  int mem_cnt = 0;
  bit mem_dead = 1'b0;
  bit stray_ack = 1'b0;
  always @(negedge w_clock) begin
    if (!w_m_req) begin
      mem_cnt   = 0;
      w_m_ack   = stray_ack;
      w_m_rdata = 32'hBAD0_BAD0;
    end else begin
      mem_cnt   = mem_cnt + 1;
      w_m_ack   = !mem_dead && (mem_cnt == mem_delay);
      w_m_rdata = mem_word(w_m_addr);
    end
  end

  // ---- model: cache contents plus the cycle schedule of the current read ----
  bit          mv [32] = '{default: 1'b0};
  logic [24:0] mt [32] = '{default: 25'd0};
  logic [31:0] md [32] = '{default: 32'd0};

  int          e_k, e_end, e_ready, e_we, e_mlo, e_mhi, cnt_cyc;
  bit          e_err;
  logic [31:0] e_addr, e_rdata;
  logic [4:0]  e_wa;
  logic [57:0] e_wd;
  int          hit_prev, hit_next, miss_prev, miss_next;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    e_k = -100; e_end = -100; e_ready = -1; e_we = -1; e_mlo = 0; e_mhi = 0;
    e_err = 1'b0; e_addr = 32'd0; e_rdata = 32'd0; e_wa = 5'd0; e_wd = 58'd0;
    hit_prev = 0; hit_next = 0; miss_prev = 0; miss_next = 0; cnt_cyc = 0;
  endtask

  // k is the clock edge that accepts the request; d is the memory ack delay
  task automatic predict(input logic [31:0] addr, input int k, input int d, input bit dead);
    logic [4:0]  idx;
    logic [24:0] tag;
    logic [31:0] data;
    idx = addr[6:2];
    tag = addr[31:7];
    hit_prev = hit_next;
    miss_prev = miss_next;
    cnt_cyc = k + 1;
    e_k = k;
    e_addr = addr;
    e_we = -1;
    e_err = 1'b0;
    if (mv[idx] && mt[idx] == tag) begin
      e_ready = k + 1; e_end = k + 1; e_mlo = 0; e_mhi = 0;
      e_rdata = md[idx];
      hit_next = sat_inc(hit_next);
    end else if (dead) begin
      e_mlo = k + 1; e_mhi = k + 1 + TO;
      e_ready = k + 1 + TO; e_end = k + 2 + TO;
      e_rdata = 32'd0; e_err = 1'b1;
      miss_next = sat_inc(miss_next);
    end else begin
      data = mem_word({addr[31:2], 2'b00});
      e_mlo = k + 1; e_mhi = k + 1 + d;
      e_we = k + 1 + d; e_wa = idx; e_wd = {1'b1, tag, data};
      e_ready = k + 2 + d; e_end = k + 3 + d;
      e_rdata = data;
      mv[idx] = 1'b1; mt[idx] = tag; md[idx] = data;
      miss_next = sat_inc(miss_next);
    end
  endtask

  // ---- per-cycle compare and monitors ----
  bit          chk_en = 1'b0;
  int          mon_we_n, mon_mreq_n, mon_ready_n, mon_ready_cyc, tot_ready = 0;
  logic [4:0]  mon_wa;
  logic [57:0] mon_wd;
  logic [31:0] mon_maddr, mon_rdata;
  logic        mon_err;

  always @(negedge w_clock) begin
    if (chk_en && w_reset_n) begin
      bit busy_e, ready_e, mreq_e, we_e;
      busy_e  = (cyc >= e_k) && (cyc < e_end);
      ready_e = (cyc == e_ready);
      mreq_e  = (cyc >= e_mlo) && (cyc < e_mhi);
      we_e    = (cyc == e_we);
      check("busy", w_busy, busy_e);
      check("ready", w_ready, ready_e);
      check("err", w_err, ready_e && e_err);
      if (ready_e || !busy_e) check("rdata", w_rdata, e_rdata);
      if (busy_e) check("c_addr", w_c_addr, e_addr);
      check("m_req", w_m_req, mreq_e);
      if (mreq_e) check("m_addr", w_m_addr, {e_addr[31:2], 2'b00});
      check("c_we", w_c_we, we_e);
      if (we_e) begin
        check("c_wa", w_c_wa, e_wa);
        check("c_wd", w_c_wd, e_wd);
      end
      check("hit_cnt", w_hit_cnt, (cyc >= cnt_cyc) ? hit_next : hit_prev);
      check("miss_cnt", w_miss_cnt, (cyc >= cnt_cyc) ? miss_next : miss_prev);
    end
    if (w_c_we) begin mon_we_n++; mon_wa = w_c_wa; mon_wd = w_c_wd; end
    if (w_m_req) begin mon_mreq_n++; mon_maddr = w_m_addr; end
    if (w_ready) begin
      mon_ready_n++; tot_ready++;
      mon_rdata = w_rdata; mon_err = w_err; mon_ready_cyc = cyc;
    end
  end

  // ---- stimulus ----
  int acc_cyc;

  task automatic reset_mid();
    #2 w_reset_n = 1'b0;
    #1;
    check("abort_busy", w_busy, 0);
    check("abort_m_req", w_m_req, 0);
    check("abort_c_we", w_c_we, 0);
    check("abort_miss_cnt", w_miss_cnt, 0);
    check("abort_rdata", w_rdata, 0);
    model_reset();
    step();
    w_reset_n = 1'b1;
    step();
  endtask

  task automatic do_read(input logic [31:0] addr, input int d, input bit dead,
                         input bit poke, input int abort_after);
    mem_delay = d;
    mem_dead = dead;
    mon_we_n = 0; mon_mreq_n = 0; mon_ready_n = 0; mon_ready_cyc = -1;
    w_req = 1'b1;
    w_addr = addr;
    acc_cyc = cyc + 1;
    predict(addr, acc_cyc, d, dead);
    step();
    if (abort_after > 0) begin
      w_req = 1'b0;
      repeat (abort_after) step();
      check("abort_pre_m_req", w_m_req, 1);
      reset_mid();
      return;
    end
    while (cyc < e_end) begin
      w_req = poke;
      w_addr = addr ^ 32'h0000_1000;
      step();
    end
    w_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int first, r0;
    model_reset();
    repeat (2) step();
    check("rst_busy", w_busy, 0);
    check("rst_ready", w_ready, 0);
    check("rst_err", w_err, 0);
    check("rst_m_req", w_m_req, 0);
    check("rst_c_we", w_c_we, 0);
    check("rst_rdata", w_rdata, 0);
    check("rst_c_addr", w_c_addr, 0);
    check("rst_hit_cnt", w_hit_cnt, 0);
    check("rst_miss_cnt", w_miss_cnt, 0);
    w_reset_n = 1'b1;
    step();
    chk_en = 1'b1;

    // cold miss, ack after 3 cycles
    do_read(32'h0000_0104, 3, 1'b0, 1'b0, 0);
    check("tp1_m_addr", mon_maddr, 32'h0000_0104);
    check("tp1_we_pulses", mon_we_n, 1);
    check("tp1_wa", mon_wa, 5'd1);
    check("tp1_wd", mon_wd, {1'b1, 25'h0000002, 32'hDEAD_BEEF});
    check("tp1_rdata", mon_rdata, 32'hDEAD_BEEF);
    check("tp1_err", mon_err, 0);
    check("tp1_latency", mon_ready_cyc - acc_cyc, 5);
    check("tp1_miss_cnt", w_miss_cnt, 1);

    // re-read hits
    do_read(32'h0000_0104, 3, 1'b0, 1'b0, 0);
    check("tp2_m_req_cycles", mon_mreq_n, 0);
    check("tp2_latency", mon_ready_cyc - acc_cyc, 1);
    check("tp2_rdata", mon_rdata, 32'hDEAD_BEEF);
    check("tp2_hit_cnt", w_hit_cnt, 1);

    // conflicting index evicts line 1, then the original address misses again
    do_read(32'h0000_0084, 2, 1'b0, 1'b0, 0);
    check("tp3_wa", mon_wa, 5'd1);
    check("tp3_wd", mon_wd, {1'b1, 25'h0000001, 32'h1234_5678});
    check("tp3_rdata", mon_rdata, 32'h1234_5678);
    do_read(32'h0000_0104, 4, 1'b0, 1'b0, 0);
    check("tp3_refetch_cycles", mon_mreq_n, 4);
    check("tp3_miss_cnt", w_miss_cnt, 3);

    // stray acks while idle must be ignored
    stray_ack = 1'b1;
    repeat (3) step();
    stray_ack = 1'b0;
    step();

    // memory never answers
    do_read(32'h0000_0200, 0, 1'b1, 1'b0, 0);
    check("to_m_req_cycles", mon_mreq_n, 8);
    check("to_err", mon_err, 1);
    check("to_rdata", mon_rdata, 0);
    check("to_we_pulses", mon_we_n, 0);
    check("to_ready_pulses", mon_ready_n, 1);
    check("to_latency", mon_ready_cyc - acc_cyc, 9);
    check("to_miss_sat", w_miss_cnt, 3);
    do_read(32'h0000_0104, 1, 1'b0, 1'b0, 0);
    check("post_to_latency", mon_ready_cyc - acc_cyc, 1);
    check("post_to_hit_cnt", w_hit_cnt, 2);

    // reset while the miss is outstanding, then the same address still misses
    do_read(32'h0000_0300, 0, 1'b1, 1'b0, 3);
    do_read(32'h0000_0300, 1, 1'b0, 1'b1, 0);
    check("abort_refetch_cycles", mon_mreq_n, 1);
    check("abort_refetch_miss", w_miss_cnt, 1);
    check("abort_refetch_hit", w_hit_cnt, 0);

    // back-to-back hits with requests poked while busy; counter saturates
    first = cyc + 1;
    r0 = tot_ready;
    for (int i = 0; i < 5; i++) do_read(32'h0000_0300, 1, 1'b0, 1'b1, 0);
    check("burst_ready_pulses", tot_ready - r0, 5);
    check("burst_span", acc_cyc - first, 8);
    check("burst_hit_sat", w_hit_cnt, 3);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
